verificador_tabla: RTL

- Hardware counterpart of an exhaustive truth-table bench: sweeps every input combination into a combinational DUT, samples its outputs and checks them against a parameterised expected table.
- Sits beside a combinational block under test (e.g. 4-in/2-out exercises) on the board.
- Reports pass/fail, error count and first failing vector over a start/busy/done handshake.

---
 rtl/tabla_pkg.sv | 22 ++
 rtl/contador_settle.sv | 33 +++
 rtl/verificador_tabla.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tabla_pkg.sv
// Shared FSM states and sizing helpers for the verificador_tabla truth-table checker.
package tabla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } estado_e;

  function automatic int tabla_w(input int n_in, input int n_out);
    return n_out * (2 ** n_in);
  endfunction

  // Ceiling log2 that never returns less than one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    while ((2 ** r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/contador_settle.sv
// Loadable down-counter for the per-vector hold time; tc_o marks the sampling cycle.
module contador_settle #(
  parameter int W      = 1,
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] CARGA = W'(SETTLE);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CARGA;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/verificador_tabla.sv
// Exhaustive truth-table checker: drives every N_IN-bit vector and compares the response
// against EXPECTED. Define TABLA_CAPTURE_EN to add the captured response-table port.
module verificador_tabla
  import tabla_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1,
  parameter logic [tabla_w(N_IN, N_OUT)-1:0] EXPECTED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   in_vec,
  input  logic [N_OUT-1:0]  out_vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err
`ifdef TABLA_CAPTURE_EN
  ,
  output logic [tabla_w(N_IN, N_OUT)-1:0] captured
`endif
);

  localparam int              CW      = clog2_min1(SETTLE + 1);
  localparam logic [N_IN-1:0] IDX_FIN = '1;

  estado_e          state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_IN-1:0]  first_q, first_d;
  logic [N_IN:0]    err_q, err_d;
  logic             pass_q, pass_d;
  logic             load, tc, mism;
  logic [N_OUT-1:0] esperado;

  contador_settle #(
    .W      (CW),
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .en_i   (state_q == APPLY),
    .tc_o   (tc)
  );

  assign esperado = EXPECTED[int'(idx_q) * N_OUT +: N_OUT];
  assign mism     = (out_vec != esperado);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          load    = 1'b1;
        end
      end
      APPLY: begin
        // tc marks the last hold cycle: out_vec is sampled on the edge that ends it.
        if (tc) begin
          if (mism) begin
            err_d = err_q + (N_IN+1)'(1);
            if (err_q == '0) first_d = idx_q;
          end
          if (idx_q == IDX_FIN) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + N_IN'(1);
            load  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  assign in_vec    = (state_q == APPLY) ? idx_q : '0;
  assign busy      = (state_q == APPLY);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_err = first_q;

`ifdef TABLA_CAPTURE_EN
  logic [tabla_w(N_IN, N_OUT)-1:0] cap_q;

  // Kept across runs; each sample overwrites its own entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
    end else if ((state_q == APPLY) && tc) begin
      cap_q[int'(idx_q) * N_OUT +: N_OUT] <= out_vec;
    end
  end

  assign captured = cap_q;
`endif

endmodule
